// File: rtl/aes_pkg.sv
// Shared AES definitions: field constant, state/word/byte types, xtime and the
// MixColumns sequencer state encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY_LO = 8'h1b;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_LO : 8'h00);
  endfunction

  // Column c occupies state bits [127-32c -: 32]; the MSB index is {~c, 5'h1f}.
  function automatic logic [6:0] word_msb(input logic [1:0] col);
    return {~col, 5'h1f};
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Upstream (ShiftRows) and downstream (AddRoundKey) valid/ready handshakes.
interface mix_columns_seq_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_data;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mix_columns_seq_word.sv
// One MixColumns column: multiply by the {02,03,01,01} circulant over GF(2^8).
module mix_column_word
  import aes_pkg::*;
(
  input  aes_word_t col_i,
  output aes_word_t col_o
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t x0, x1, x2, x3;

  assign {a0, a1, a2, a3} = col_i;

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a = xtime(a) ^ a
  assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: mixes COLS_PER_CYCLE columns per clock, bypass on the final round.
// state | meaning
// IDLE  | waiting for a state from upstream
// BUSY  | writing col_cnt.. columns into the result register
// DONE  | result presented, waiting for downstream
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mix_columns_seq_if.slave  bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP      = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);

  mc_state_e  state_q, state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  aes_state_t data_q, data_d;
  aes_state_t result_q, result_d;
  logic       last_q, last_d;

  aes_word_t  col_in  [COLS_PER_CYCLE];
  aes_word_t  col_mix [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    logic [1:0] col_idx;
    assign col_idx   = col_cnt_q + 2'(g);
    assign col_in[g] = data_q[word_msb(col_idx) -: 32];

    mix_column_word u_mix (
      .col_i (col_in[g]),
      .col_o (col_mix[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;
    result_d  = result_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d    = bus.in_data;
          last_d    = bus.in_last;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          result_d[word_msb(col_cnt_q + 2'(j)) -: 32] = last_q ? col_in[j] : col_mix[j];
        end
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST_BASE) begin
          col_cnt_d = 2'd0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      data_q    <= '0;
      result_q  <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
      result_q  <= result_d;
      last_q    <= last_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = result_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and random bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mix_columns_seq_if bus1 ();
  mix_columns_seq_if bus2 ();
  mix_columns_seq_if bus4 ();

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic last);
    logic [127:0] r = '0;
    logic [7:0]   a [4];
    if (last) return s;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 8 * (4 * c + k) -: 8];
      for (int k = 0; k < 4; k++)
        r[127 - 8 * (4 * c + k) -: 8] = gmul(a[k], 8'h02) ^ gmul(a[(k + 1) % 4], 8'h03)
                                        ^ a[(k + 2) % 4] ^ a[(k + 3) % 4];
    end
    return r;
  endfunction

  typedef struct {
    logic [127:0] din;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  // Drive one state into dut1, measure edges from accept to out_valid, optionally consume.
  task automatic xfer1(input logic [127:0] d, input logic l, input bit consume,
                       output int lat, output logic [127:0] q);
    int w = 0;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    bus1.in_last  = l;
    while (!bus1.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (w >= 20) lat = 99;
    q = bus1.out_data;
    if (consume) begin
      bus1.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.out_ready = 1'b0;
    end
  endtask

  initial begin
    int lat, lat2, lat4;
    logic [127:0] q, q2, q4;
    bit ok;
    logic [127:0] exp_q [$];
    int sent, recv;
    logic [127:0] cur_d;
    logic cur_l;
    bit have;

    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
    vecs[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff};
    vecs[3] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
    vecs[4] = '{128'hc6c6c6c6_01010101_f20a225c_db135345, 1'b0, 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc};
    vecs[5] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vecs[6] = '{128'h0, 1'b0, 128'h0};

    bus1.in_valid = 0; bus1.in_data = '0; bus1.in_last = 0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.in_last = 0; bus2.out_ready = 1;
    bus4.in_valid = 0; bus4.in_data = '0; bus4.in_last = 0; bus4.out_ready = 1;

    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 128'(bus1.in_ready), 128'h0);
    check("rst_out_valid", 128'(bus1.out_valid), 128'h0);
    check("rst_out_data", bus1.out_data, 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", 128'(bus1.in_ready), 128'h1);

    for (int i = 0; i < 7; i++) begin
      xfer1(vecs[i].din, vecs[i].last, 1'b1, lat, q);
      check($sformatf("vec%0d_data", i), q, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
    end

    // Latency of the wider configurations on the App.B round-1 state.
    @(negedge clk);
    bus2.in_valid = 1; bus2.in_data = vecs[1].din; bus2.in_last = 0;
    bus4.in_valid = 1; bus4.in_data = vecs[1].din; bus4.in_last = 0;
    check("p2_in_ready", 128'(bus2.in_ready), 128'h1);
    check("p4_in_ready", 128'(bus4.in_ready), 128'h1);
    @(posedge clk);
    @(negedge clk);
    bus2.in_valid = 0; bus4.in_valid = 0;
    lat2 = -1; lat4 = -1; q2 = '0; q4 = '0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) begin
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      if (bus2.out_valid && lat2 < 0) begin lat2 = n; q2 = bus2.out_data; end
      if (bus4.out_valid && lat4 < 0) begin lat4 = n; q4 = bus4.out_data; end
    end
    check("p2_latency", 128'(lat2), 128'd2);
    check("p4_latency", 128'(lat4), 128'd1);
    check("p2_data", q2, vecs[1].exp);
    check("p4_data", q4, vecs[1].exp);

    // Backpressure: hold out_ready low with a competing in_valid.
    xfer1(vecs[1].din, 1'b0, 1'b0, lat, q);
    check("bp_first_data", q, vecs[1].exp);
    bus1.in_valid = 1; bus1.in_data = vecs[3].din; bus1.in_last = 0;
    ok = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!bus1.out_valid || bus1.out_data !== vecs[1].exp || bus1.in_ready) ok = 0;
    end
    check("bp_hold", 128'(ok), 128'h1);
    bus1.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus1.out_ready = 0;
    check("bp_ready_next", 128'(bus1.in_ready), 128'h1);
    check("bp_valid_drop", 128'(bus1.out_valid), 128'h0);
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp_second_latency", 128'(lat), 128'd4);
    check("bp_second_data", bus1.out_data, vecs[3].exp);
    bus1.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus1.out_ready = 0;

    // Reset while columns 0 and 1 are written and column 2 is next.
    bus1.in_valid = 1; bus1.in_data = vecs[4].din; bus1.in_last = 0;
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(bus1.out_valid), 128'h0);
    check("midrst_out_data", bus1.out_data, 128'h0);
    check("midrst_in_ready", 128'(bus1.in_ready), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_idle", 128'(bus1.in_ready), 128'h1);
    xfer1(vecs[0].din, 1'b0, 1'b1, lat, q);
    check("midrst_next_data", q, vecs[0].exp);
    check("midrst_next_latency", 128'(lat), 128'd4);

    // Random traffic against the reference model.
    sent = 0; recv = 0; have = 0; cur_d = '0; cur_l = 0;
    for (int cyc = 0; cyc < 40000 && recv < 1000; cyc++) begin
      @(negedge clk);
      if (!have && sent < 1000) begin
        cur_d = {$urandom, $urandom, $urandom, $urandom};
        cur_l = ($urandom_range(7) == 0);
        have  = 1;
      end
      bus1.in_valid  = have && ($urandom_range(3) != 0);
      bus1.in_data   = cur_d;
      bus1.in_last   = cur_l;
      bus1.out_ready = ($urandom_range(2) != 0);
      #1;
      if (bus1.in_valid && bus1.in_ready) begin
        exp_q.push_back(ref_mix(cur_d, cur_l));
        have = 0;
        sent++;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_unexpected actual=%h required=none", bus1.out_data);
        end else begin
          check("rnd_data", bus1.out_data, exp_q.pop_front());
        end
        recv++;
      end
    end
    bus1.in_valid = 0;
    bus1.out_ready = 0;
    check("rnd_count", 128'(recv), 128'd1000);
    check("rnd_leftover", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
